// File: rtl/pow2_bound_pipe.sv
// Power-of-two bounding unit (NEXT / CEIL / FLOOR) with exponent and flags.
// Latency: LVL+1 cycles, where LVL = clog2(WIDTH). Throughput is one result per cycle.
// Backpressure: one global advance (out_ready | ~out_valid) shifts or freezes every stage together.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              operand handshake; in_ready is combinational from out_ready
//   in_data, in_mode, in_tag       operand, mode (0 NEXT, 1 CEIL, 2 FLOOR, 3 = NEXT), sideband tag
//   out_valid/out_ready            result handshake
//   out_data, out_log2             one-hot result (or 0) and its bit index
//   out_ovf, out_zero, out_tag     overflow flag, zero-operand flag, returned tag
module pow2_bound_pipe #(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    localparam int LVL   = $clog2(WIDTH),
    localparam int EW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [EW-1:0]    out_log2,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] MODE_CEIL  = 2'd1;
    localparam logic [1:0] MODE_FLOOR = 2'd2;

    // Prefix stages: index k holds the result of doubling step k+1 (distance 2^k).
    logic [LVL-1:0]   vld_q;
    logic [WIDTH-1:0] mid_q  [LVL];
    logic [WIDTH-1:0] mid_d  [LVL];
    logic [WIDTH-1:0] raw_q  [LVL];
    logic [1:0]       mode_q [LVL];
    logic [TAG_W-1:0] tag_q  [LVL];

    // Output register stage.
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [EW-1:0]    out_log2_q, out_log2_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_zero_q;
    logic [TAG_W-1:0] out_tag_q;

    logic adv;

    assign adv      = out_ready | ~out_valid_q;
    assign in_ready = adv;

    // Downward prefix OR: after step k, bit i is the OR of in[min(i+2^(k+1)-1, WIDTH-1):i].
    // The logical right shift fills with zeros, so bits above the MSB contribute nothing.
    always_comb begin
        mid_d[0] = in_data | (in_data >> 1);
        for (int k = 1; k < LVL; k++) begin
            mid_d[k] = mid_q[k-1] | (mid_q[k-1] >> (1 << k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < LVL; k++) begin
                mid_q[k]  <= '0;
                raw_q[k]  <= '0;
                mode_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else if (adv) begin
            // Bubbles travel with in_valid = 0; their payload is never consumed.
            vld_q[0]  <= in_valid;
            raw_q[0]  <= in_data;
            mode_q[0] <= in_mode;
            tag_q[0]  <= in_tag;
            for (int k = 1; k < LVL; k++) begin
                vld_q[k]  <= vld_q[k-1];
                raw_q[k]  <= raw_q[k-1];
                mode_q[k] <= mode_q[k-1];
                tag_q[k]  <= tag_q[k-1];
            end
            for (int k = 0; k < LVL; k++) begin
                mid_q[k] <= mid_d[k];
            end
        end
    end

    // Final stage: isolate the MSB, test for an exact power of two, pick the mode's result.
    logic [WIDTH-1:0] raw_l, msb_oh;
    logic [EW-1:0]    m_enc;
    logic             is_zero, is_pow2, top_set;

    always_comb begin
        raw_l   = raw_q[LVL-1];
        msb_oh  = mid_q[LVL-1] & ~(mid_q[LVL-1] >> 1);
        is_zero = ~|raw_l;
        is_pow2 = ~|(raw_l & ~msb_oh);
        top_set = msb_oh[WIDTH-1];
        // msb_oh is one-hot (or zero), so OR-ing the indices of set bits is an exact encoder.
        m_enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (msb_oh[i]) begin
                m_enc = m_enc | EW'(i);
            end
        end
    end

    always_comb begin
        out_data_d = '0;
        out_log2_d = '0;
        out_ovf_d  = 1'b0;
        case (mode_q[LVL-1])
            MODE_FLOOR: begin
                // Zero operand gives msb_oh = 0 and m_enc = 0 naturally.
                out_data_d = msb_oh;
                out_log2_d = m_enc;
            end
            MODE_CEIL: begin
                if (is_zero) begin
                    out_data_d = WIDTH'(1);
                end else if (is_pow2) begin
                    out_data_d = msb_oh;
                    out_log2_d = m_enc;
                end else if (top_set) begin
                    out_ovf_d  = 1'b1;
                    out_log2_d = EW'(WIDTH);
                end else begin
                    out_data_d = msb_oh << 1;
                    out_log2_d = m_enc + EW'(1);
                end
            end
            default: begin
                // NEXT, and the reserved encoding 3.
                if (is_zero) begin
                    out_data_d = WIDTH'(1);
                end else if (top_set) begin
                    out_ovf_d  = 1'b1;
                    out_log2_d = EW'(WIDTH);
                end else begin
                    out_data_d = msb_oh << 1;
                    out_log2_d = m_enc + EW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_log2_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= vld_q[LVL-1];
            if (vld_q[LVL-1]) begin
                out_data_q <= out_data_d;
                out_log2_q <= out_log2_d;
                out_ovf_q  <= out_ovf_d;
                out_zero_q <= is_zero;
                out_tag_q  <= tag_q[LVL-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_log2  = out_log2_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;
    assign out_tag   = out_tag_q;

endmodule

// File: doc/pow2_bound_pipe.md
# pow2_bound_pipe

Pipelined, parameterised power-of-two bounding unit for the Goldschmidt datapath. It returns one of three results for each operand: the next-higher bit, the true power-of-two ceiling, or the floor. Each result comes with its exponent and overflow/zero flags. It sits ahead of the divider's initial-estimate and normalisation logic. It replaces the flat asynchronous ripple-OR with a log-depth registered prefix-OR tree behind a valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width; legal range ≥ 2, any value (need not be a power of two)
- TAG_W, 4, sideband tag width carried alongside each operand; legal range ≥ 1
- Derived: LVL = clog2(WIDTH), EW = clog2(WIDTH)+1, latency L = LVL+1

Ports (clock and reset first):
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand presented
- in_ready  out  1  unit can accept this cycle
- in_data  in  WIDTH  operand, unsigned
- in_mode  in  2  0 = NEXT, 1 = CEIL, 2 = FLOOR, 3 = reserved (treated as NEXT)
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  one-hot result, or 0
- out_log2  out  EW  bit index of the set bit in out_data
- out_ovf  out  1  result not representable in WIDTH bits
- out_zero  out  1  operand was zero
- out_tag  out  TAG_W  tag of this result

## Operation
Let m be the index of the most-significant set bit of in_data.
- NEXT (legacy behaviour):
  - out_data = 1<<(m+1)
  - in_data==0 → out_data = 1, log2 = 0
  - m==WIDTH-1 → out_data = 0, ovf = 1, log2 = WIDTH
- CEIL: smallest power of two ≥ in_data.
  - in_data==0 → out_data = 1
  - in_data a power of two → out_data = in_data
  - otherwise 1<<(m+1); overflow when in_data > 2^(WIDTH-1) → out_data = 0, ovf = 1, log2 = WIDTH
- FLOOR:
  - out_data = 1<<m, log2 = m
  - in_data==0 → out_data = 0, log2 = 0, ovf = 0
- out_zero = (in_data==0) in every mode; out_ovf is never set in FLOOR.
- Prefix-OR datapath:
  - Stages 1..LVL each perform one doubling step of the downward prefix OR (mid[i] = OR of in[WIDTH-1:i]).
  - Distances are 1, 2, 4, …; bits beyond the MSB are treated as 0.
  - Each stage is registered. Mode, tag and raw operand travel with the data.
- Final stage (L):
  - Forms the one-hot MSB h = mid & ~(mid>>1).
  - Power-of-two test: (in & ~h) == 0.
  - Selects the result per mode, encodes log2 and computes the flags; outputs are registered.
- The encoder and the prefix tree are generate-built from WIDTH; no width-specific code.

## Timing
- Reset (asynchronous, rst_n low):
  - All stage valid bits clear; out_valid = 0, out_data = 0, out_log2 = 0, out_ovf = 0, out_zero = 0, out_tag = 0.
  - In-flight operands are discarded; no result emerges for them.
  - in_ready = 1 once rst_n is high and out_valid = 0.
- Global advance: adv = out_ready | ~out_valid.
  - in_ready = adv (combinational from out_ready, no registered path).
  - All stages shift together when adv = 1 and hold when adv = 0. Bubbles shift through like data.
- Transfers:
  - Accept occurs on a rising edge with in_valid & in_ready.
  - Output transfer occurs on a rising edge with out_valid & out_ready.
- Latency: exactly L cycles from accept to out_valid when no stall occurs (WIDTH=32 → 6; WIDTH=5 → 4).
- Throughput: one result per cycle with out_ready held high.
- Stall: while out_valid & ~out_ready, all out_* signals are held stable. No operand is lost, duplicated or reordered.
- Simultaneous output transfer and new accept in the same cycle is legal and needs no bubble.
- in_data, in_mode and in_tag are sampled only on accept; they are don't-care otherwise.

## Test plan
- WIDTH=32, mode 0:
  - 0x2 → 0x4, log2 2
  - 0x5 → 0x8, log2 3
  - 0x0 → 0x1, zero = 1
  - 0x80000000 → 0x0, ovf = 1, log2 32
  - Each result must appear exactly 6 cycles after accept.
- WIDTH=32, mode 1:
  - 0x10 → 0x10, log2 4
  - 0x11 → 0x20, log2 5
  - 0x80000000 → 0x80000000, log2 31
  - 0x80000001 → 0x0, ovf = 1
- WIDTH=32, mode 2:
  - 0x12345678 → 0x10000000, log2 28
  - 0x0 → 0x0, zero = 1, ovf = 0
  - mode 3 with 0x2 → 0x4 (same as NEXT)
- 1000 random back-to-back operands with random out_ready:
  - Results match the reference model in order and tags match.
  - out_* stay stable during stalls.
  - in_ready tracks out_ready | ~out_valid every cycle.
- Assert rst_n low with 4 operands in flight, then release:
  - out_valid = 0 during reset; no stale result appears afterwards.
  - The first new operand emerges after L cycles.
- WIDTH=5, mode 0:
  - 0x0F → 0x10
  - 0x10 → 0x0, ovf = 1, log2 5
  - Latency 4; exhaustive sweep of all 32 operands in all modes.
